tag_free_list: RTL
==================

// Module: tag_free_list
// PURPOSE
//  Circular free list of physical register tags. Sits in rename, upstream of the rename table.
//  Hands out up to NUM_ISSUE fresh tags per cycle, which become the rename table's issue tags.
//  Reclaims the previous tags of committed instructions (the rename table's commit previous-tag
//  outputs) and rolls speculative allocations back on a mispredict.
// PARAMETERS
//  NUM_ISSUE  4   max tag allocations per cycle
//  NUM_COMMIT 4   max commits (frees) per cycle
//  NUM_TAGS   64  physical tags, numbered 0..NUM_TAGS-1; must be a power of 2
//  TAG_SIZE   7   tag width; bit 6 set = not a physical tag (e.g. 7'h40), never stored
// PORTS
//  clk              in   1                     clock
//  rst              in   1                     synchronous, active-high reset
//  IN_mispred       in   1                     flush: roll speculative head back to committed head
//  IN_allocValid    in   NUM_ISSUE             per-slot tag request
//  OUT_allocTags    out  NUM_ISSUE*TAG_SIZE    tag granted per slot (combinational)
//  OUT_ready        out  1                     registered; >=NUM_ISSUE tags free speculatively
//  IN_commitValid   in   NUM_COMMIT            committing slot valid
//  IN_commitAlloc   in   NUM_COMMIT            slot consumed a free-list tag at rename
//  IN_commitPrevTag in   NUM_COMMIT*TAG_SIZE   tag displaced by this commit; freed unless bit 6 set
//  OUT_freeCount    out  $clog2(NUM_TAGS)+1    registered count of speculatively free tags
// BEHAVIOUR
//  Storage and pointers
//   - list[NUM_TAGS] holds 6-bit tags.
//   - Pointers specHead, commitHead and tail are $clog2(NUM_TAGS)+1 bits wide; the MSB is the wrap bit.
//   - freeCount = tail - specHead, computed modulo 2^(ptr width). Equal index with different wrap bit = full.
//  Reset
//   - list[i]=i; specHead=commitHead=0; tail={1,0..0}, i.e. all NUM_TAGS tags free.
//   - OUT_ready=1; OUT_freeCount=NUM_TAGS.
//  Allocation
//   - The k-th set bit of IN_allocValid (counting from bit 0) receives {1'b0, list[specHead+k]}.
//   - Unrequested slots output 7'h40.
//   - An allocation takes effect only if OUT_ready=1 and IN_mispred=0. Then specHead += popcount(IN_allocValid).
//   - If OUT_ready=0, OUT_allocTags are don't-care and no pointer moves. The upstream stage must stall.
//  Commit / free (unconditional, including in mispred cycles)
//   - commitHead += count of slots with commitValid & commitAlloc.
//   - Each slot with commitValid and prevTag[6]==0 writes prevTag[5:0] to list[tail+m], where m is the
//     compacted index among freeing slots, in slot order. Then tail += number freed.
//   - Freed tags are allocatable no earlier than the next cycle.
//  Mispredict
//   - specHead <= commitHead + (allocating commits this cycle). Any same-cycle allocation is dropped.
//  OUT_ready / OUT_freeCount
//   - Computed from post-update pointers and registered.
//   - Allocation latency is 0 cycles (tags are combinational from list and specHead).
//   - Frees reach OUT_ready one cycle after the commit.
//  Wrap-around: all pointer and list-index arithmetic is modulo NUM_TAGS; the wrap bit toggles on pass.
//  Illegal conditions (simulation assertions, no recovery):
//   - a free that would make freeCount exceed NUM_TAGS;
//   - commitHead passing specHead.
//  Reset mid-operation: reset wins over every input, and the list is re-initialised to identity.
// TESTING
//  1. Reset, then allocValid=4'b1111 for 1 cycle -> tags 0,1,2,3; next cycle freeCount=60, ready=1.
//  2. allocValid=4'b1010 after T1 -> slot1=4, slot3=5, slots 0 and 2 = 7'h40; specHead advances by 2.
//  3. Allocate 16 cycles x4 -> freeCount=0, ready=0.
//     Then commit 1 slot with prevTag=7'h40 -> nothing freed.
//     Then commit 1 slot with prevTag=9 -> freeCount=1, ready still 0.
//  4. Allocate 8 tags and commit (alloc=1) 3 of them, then pulse IN_mispred together with a 4-wide
//     alloc -> alloc dropped; specHead=commitHead=3; next alloc returns list[3].
//  5. Wrap: allocate and free 70 tags in a steady stream with prevTags = allocated tags minus 8 ->
//     tail/specHead wrap bits toggle, no assertion fires, tags come back in freed order.
//  6. Assert rst while freeCount=10 and commits are in flight -> next cycle freeCount=64 and first
//     alloc returns tag 0.

Source files
------------

// File: rtl/tag_free_list.sv
// Circular free list of physical register tags: grants up to NUM_ISSUE tags/cycle, reclaims committed previous tags.
// Latency: granted tags are combinational (0 cycles); OUT_ready/OUT_freeCount are registered (frees visible next cycle).
// Backpressure: OUT_ready=0 freezes allocation and upstream must stall; commits/frees are never back-pressured.
module tag_free_list #(
    parameter int NUM_ISSUE  = 4,
    parameter int NUM_COMMIT = 4,
    parameter int NUM_TAGS   = 64,
    parameter int TAG_SIZE   = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            IN_mispred,
    input  logic [NUM_ISSUE-1:0]            IN_allocValid,
    output logic [NUM_ISSUE*TAG_SIZE-1:0]   OUT_allocTags,
    output logic                            OUT_ready,
    input  logic [NUM_COMMIT-1:0]           IN_commitValid,
    input  logic [NUM_COMMIT-1:0]           IN_commitAlloc,
    input  logic [NUM_COMMIT*TAG_SIZE-1:0]  IN_commitPrevTag,
    output logic [$clog2(NUM_TAGS):0]       OUT_freeCount
);
    localparam int IDX_W = $clog2(NUM_TAGS);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [TAG_SIZE-1:0] NO_TAG = {1'b1, {(TAG_SIZE-1){1'b0}}};

    logic [IDX_W-1:0] list_q [NUM_TAGS];

    // Pointers carry one extra wrap bit so full (equal index, different wrap) differs from empty.
    logic [PTR_W-1:0] spec_head_q, commit_head_q, tail_q;
    logic [PTR_W-1:0] spec_head_nxt, commit_head_nxt, tail_nxt;
    logic [PTR_W-1:0] free_count_nxt, commit_gap_nxt;
    logic [PTR_W-1:0] alloc_cnt, cmt_cnt, free_cnt;
    logic [IDX_W-1:0] rd_idx;
    logic             ready_nxt;

    logic             wr_en  [NUM_COMMIT];
    logic [IDX_W-1:0] wr_idx [NUM_COMMIT];
    logic [IDX_W-1:0] wr_tag [NUM_COMMIT];

    // Grant the k-th requesting slot the k-th entry past the speculative head.
    always_comb begin
        OUT_allocTags = '0;
        alloc_cnt     = '0;
        rd_idx        = '0;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            rd_idx = spec_head_q[IDX_W-1:0] + alloc_cnt[IDX_W-1:0];
            if (IN_allocValid[i]) begin
                OUT_allocTags[i*TAG_SIZE +: TAG_SIZE] = {{(TAG_SIZE-IDX_W){1'b0}}, list_q[rd_idx]};
                alloc_cnt = alloc_cnt + PTR_W'(1);
            end else begin
                OUT_allocTags[i*TAG_SIZE +: TAG_SIZE] = NO_TAG;
            end
        end
    end

    // Compact freeing commit slots onto consecutive list entries starting at the tail.
    always_comb begin
        cmt_cnt  = '0;
        free_cnt = '0;
        for (int j = 0; j < NUM_COMMIT; j++) begin
            wr_en[j]  = 1'b0;
            wr_idx[j] = '0;
            wr_tag[j] = IN_commitPrevTag[j*TAG_SIZE +: IDX_W];
            if (IN_commitValid[j] && IN_commitAlloc[j]) begin
                cmt_cnt = cmt_cnt + PTR_W'(1);
            end
            if (IN_commitValid[j] && !IN_commitPrevTag[j*TAG_SIZE + TAG_SIZE - 1]) begin
                wr_en[j]  = 1'b1;
                wr_idx[j] = tail_q[IDX_W-1:0] + free_cnt[IDX_W-1:0];
                free_cnt  = free_cnt + PTR_W'(1);
            end
        end
    end

    // Next pointers: mispredict rolls back to the post-commit head and drops any same-cycle allocation.
    always_comb begin
        commit_head_nxt = commit_head_q + cmt_cnt;
        tail_nxt        = tail_q + free_cnt;
        if (IN_mispred) begin
            spec_head_nxt = commit_head_nxt;
        end else if (OUT_ready) begin
            spec_head_nxt = spec_head_q + alloc_cnt;
        end else begin
            spec_head_nxt = spec_head_q;
        end
        free_count_nxt = tail_nxt - spec_head_nxt;
        commit_gap_nxt = spec_head_nxt - commit_head_nxt;
        ready_nxt      = (free_count_nxt >= PTR_W'(NUM_ISSUE));
    end

    // Pointer and status registers; status is derived from the post-update pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= PTR_W'(NUM_TAGS);
            OUT_ready     <= 1'b1;
            OUT_freeCount <= PTR_W'(NUM_TAGS);
        end else begin
            spec_head_q   <= spec_head_nxt;
            commit_head_q <= commit_head_nxt;
            tail_q        <= tail_nxt;
            OUT_ready     <= ready_nxt;
            OUT_freeCount <= free_count_nxt;
        end
    end

    // List storage: identity on reset, otherwise write back freed tags at their compacted positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                list_q[i] <= IDX_W'(i);
            end
        end else begin
            for (int j = 0; j < NUM_COMMIT; j++) begin
                if (wr_en[j]) begin
                    list_q[wr_idx[j]] <= wr_tag[j];
                end
            end
        end
    end

    // Over-freeing or committing past the speculative head means upstream bookkeeping is broken.
    a_no_overfree: assert property (@(posedge clk) disable iff (rst)
        free_count_nxt <= PTR_W'(NUM_TAGS));
    a_commit_behind_spec: assert property (@(posedge clk) disable iff (rst)
        commit_gap_nxt <= PTR_W'(NUM_TAGS));

endmodule
